// File: rtl/fb_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_arb_pkg                                                               |
// | Shared types and constants for the frame-buffer read arbiter.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CNN  = 2'd1,
    S_COOL = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CNN = 1'b1
  } owner_t;

  localparam int FB_ADDR_W_DEF = 19;
  localparam int PIX_W_DEF     = 4;
  localparam int HREZ          = 640;
  localparam int VREZ          = 480;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_arb_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_arb_tag_pipe                                                          |
// | RD_LAT-deep {valid, owner} shift register tracking in-flight reads.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fb_arb_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  owner_t in_owner,
  output logic   out_valid,
  output owner_t out_owner
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] owner_q, owner_d;

  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    valid_d[0] = in_valid;
    owner_d[0] = in_owner;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_owner = owner_t'(owner_q[RD_LAT-1]);

endmodule
`default_nettype wire

// File: rtl/fb_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_read_arbiter                                                          |
// | Shares the frame-buffer read port: VGA scanout first, CNN in the gaps.   |
// | Optional statistics counters built when ARB_STATS_EN is defined.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int FB_ADDR_W = FB_ADDR_W_DEF,
  parameter int PIX_W     = PIX_W_DEF,
  parameter int RD_LAT    = 2,
  parameter int BURST_LEN = 8
) (
  input  logic                 clk24,
  input  logic                 rst,
  input  logic                 vga_req,
  input  logic [FB_ADDR_W-1:0] vga_addr,
  output logic [PIX_W-1:0]     vga_pixel,
  output logic                 vga_pvalid,
  input  logic                 cnn_req,
  input  logic [FB_ADDR_W-1:0] cnn_addr,
  output logic                 cnn_gnt,
  output logic                 cnn_rvalid,
  output logic [PIX_W-1:0]     cnn_rdata,
  output logic                 fb_en,
  output logic [FB_ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]     fb_rdata,
  output logic [15:0]          stat_wait_max,
  output logic [15:0]          stat_preempt
);

  localparam logic [7:0] C_BURST_LEN = 8'(BURST_LEN);

  arb_state_t           state_q, state_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0]     vga_pixel_q, vga_pixel_d;
  logic [PIX_W-1:0]     cnn_rdata_q, cnn_rdata_d;
  logic                 cnn_grant;
  owner_t               issue_owner;
  logic                 tag_valid;
  owner_t               tag_owner;
  logic                 vga_hit, cnn_hit;

  // Burst FSM: the grant that completes a burst moves straight to the cooldown slot.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    cnn_grant  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnn_req && !vga_req) begin
          cnn_grant = 1'b1;
          if (C_BURST_LEN == 8'd1) begin
            state_d    = S_COOL;
            beat_cnt_d = 8'd0;
          end else begin
            state_d    = S_CNN;
            beat_cnt_d = 8'd1;
          end
        end
      end
      S_CNN: begin
        if (vga_req || !cnn_req) begin
          state_d    = S_IDLE;
          beat_cnt_d = 8'd0;
        end else begin
          cnn_grant = 1'b1;
          if (beat_cnt_q + 8'd1 == C_BURST_LEN) begin
            state_d    = S_COOL;
            beat_cnt_d = 8'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      S_COOL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    issue_owner = vga_req ? OWN_VGA : OWN_CNN;
    if (vga_req) begin
      fb_addr_d = vga_addr;
    end else if (cnn_grant) begin
      fb_addr_d = cnn_addr;
    end else begin
      fb_addr_d = fb_addr_q;
    end
  end

  assign fb_en   = vga_req | cnn_grant;
  assign fb_addr = fb_addr_d;
  assign cnn_gnt = cnn_grant;

  fb_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk24),
    .rst       (rst),
    .in_valid  (fb_en),
    .in_owner  (issue_owner),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  // Return data bypasses straight through on its strobe and is held between strobes.
  always_comb begin
    vga_hit     = tag_valid && (tag_owner == OWN_VGA);
    cnn_hit     = tag_valid && (tag_owner == OWN_CNN);
    vga_pixel_d = vga_hit ? fb_rdata : vga_pixel_q;
    cnn_rdata_d = cnn_hit ? fb_rdata : cnn_rdata_q;
  end

  assign vga_pixel  = vga_pixel_d;
  assign vga_pvalid = vga_hit;
  assign cnn_rdata  = cnn_rdata_d;
  assign cnn_rvalid = cnn_hit;

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= 8'd0;
      fb_addr_q   <= '0;
      vga_pixel_q <= '0;
      cnn_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      fb_addr_q   <= fb_addr_d;
      vga_pixel_q <= vga_pixel_d;
      cnn_rdata_q <= cnn_rdata_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] wait_max_q, wait_max_d;
  logic [15:0] preempt_q, preempt_d;
  logic        arb_preempt;

  always_comb begin
    arb_preempt = (state_q == S_CNN) && vga_req;
    if (cnn_grant) begin
      wait_cnt_d = 16'd0;
    end else if (cnn_req) begin
      wait_cnt_d = sat_inc16(wait_cnt_q);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    wait_max_d = (wait_cnt_d > wait_max_q) ? wait_cnt_d : wait_max_q;
    preempt_d  = arb_preempt ? sat_inc16(preempt_q) : preempt_q;
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 16'd0;
      wait_max_q <= 16'd0;
      preempt_q  <= 16'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wait_max_q <= wait_max_d;
      preempt_q  <= preempt_d;
    end
  end

  assign stat_wait_max = wait_max_q;
  assign stat_preempt  = preempt_q;
`else
  assign stat_wait_max = 16'd0;
  assign stat_preempt  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_read_arbiter                                                       |
// | Scoreboard bench for fb_read_arbiter with a 2-cycle frame-buffer model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fb_read_arbiter;

  localparam int AW  = 19;
  localparam int PW  = 4;
  localparam int LAT = 2;

  logic          clk24 = 1'b0;
  logic          rst = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          cnn_req = 1'b0;
  logic [AW-1:0] cnn_addr = '0;
  logic [PW-1:0] vga_pixel, cnn_rdata, fb_rdata;
  logic          vga_pvalid, cnn_gnt, cnn_rvalid, fb_en;
  logic [AW-1:0] fb_addr;
  logic [15:0]   stat_wait_max, stat_preempt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic       own_cnn;
    logic [3:0] data;
  } exp_t;
  exp_t sb[$];

  fb_read_arbiter #(
    .FB_ADDR_W (AW),
    .PIX_W     (PW),
    .RD_LAT    (LAT),
    .BURST_LEN (8)
  ) dut (
    .clk24         (clk24),
    .rst           (rst),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_pixel     (vga_pixel),
    .vga_pvalid    (vga_pvalid),
    .cnn_req       (cnn_req),
    .cnn_addr      (cnn_addr),
    .cnn_gnt       (cnn_gnt),
    .cnn_rvalid    (cnn_rvalid),
    .cnn_rdata     (cnn_rdata),
    .fb_en         (fb_en),
    .fb_addr       (fb_addr),
    .fb_rdata      (fb_rdata),
    .stat_wait_max (stat_wait_max),
    .stat_preempt  (stat_preempt)
  );

  always #5 clk24 = ~clk24;
  always @(posedge clk24) cyc <= cyc + 1;

  // Frame buffer: returns addr[3:0] two cycles after the address is presented.
  logic [AW-1:0] fb_s0 = '0;
  logic [AW-1:0] fb_s1 = '0;
  always @(posedge clk24) begin
    fb_s0 <= fb_addr;
    fb_s1 <= fb_s0;
  end
  assign fb_rdata = fb_s1[3:0];

  // Return-path scoreboard: every cycle the strobes and held data must match the queue head.
  logic       m_ev, m_ec;
  logic [3:0] m_ed;
  logic [3:0] last_vga = 4'd0;
  logic [3:0] last_cnn = 4'd0;
  always @(negedge clk24) begin
    m_ev = 1'b0;
    m_ec = 1'b0;
    m_ed = 4'd0;
    if (rst) begin
      last_vga = 4'd0;
      last_cnn = 4'd0;
    end
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      m_ev = !sb[0].own_cnn;
      m_ec = sb[0].own_cnn;
      m_ed = sb[0].data;
      void'(sb.pop_front());
    end
    if (m_ev) last_vga = m_ed;
    if (m_ec) last_cnn = m_ed;
    n_checks++;
    if (vga_pvalid !== m_ev) begin
      n_fail++;
      $display("FAIL vga_pvalid cyc %0d: got %0b expected %0b", cyc, vga_pvalid, m_ev);
    end
    n_checks++;
    if (cnn_rvalid !== m_ec) begin
      n_fail++;
      $display("FAIL cnn_rvalid cyc %0d: got %0b expected %0b", cyc, cnn_rvalid, m_ec);
    end
    n_checks++;
    if (vga_pixel !== last_vga) begin
      n_fail++;
      $display("FAIL vga_pixel cyc %0d: got %0h expected %0h", cyc, vga_pixel, last_vga);
    end
    n_checks++;
    if (cnn_rdata !== last_cnn) begin
      n_fail++;
      $display("FAIL cnn_rdata cyc %0d: got %0h expected %0h", cyc, cnn_rdata, last_cnn);
    end
  end

  task automatic drive(input logic vr, input logic [AW-1:0] va,
                       input logic cr, input logic [AW-1:0] ca);
    @(posedge clk24);
    #1;
    vga_req  = vr;
    vga_addr = va;
    cnn_req  = cr;
    cnn_addr = ca;
    #2;
  endtask

  task automatic expect_read(input logic own_cnn, input logic [AW-1:0] a);
    exp_t e;
    e.due     = cyc + LAT;
    e.own_cnn = own_cnn;
    e.data    = a[3:0];
    sb.push_back(e);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, '0);
      n_checks++;
      if ({fb_en, cnn_gnt, vga_pvalid, cnn_rvalid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_strobes: got %b expected 0000", {fb_en, cnn_gnt, vga_pvalid, cnn_rvalid});
      end
      n_checks++;
      if ({fb_addr, vga_pixel, cnn_rdata, stat_wait_max, stat_preempt} !== '0) begin
        n_fail++;
        $display("FAIL reset_data: got %0h/%0h/%0h/%0h/%0h expected all 0",
                 fb_addr, vga_pixel, cnn_rdata, stat_wait_max, stat_preempt);
      end
    end
    @(posedge clk24);
    #1 rst = 1'b0;
  endtask

  // Active line with CNN waiting throughout, then the first blank cycle.
  task automatic test_vga_line;
    logic [15:0] exp_wm;
    for (int i = 0; i < 640; i++) begin
      drive(1'b1, AW'(i), 1'b1, 19'h0ABCD);
      expect_read(1'b0, AW'(i));
      n_checks++;
      if (fb_en !== 1'b1 || fb_addr !== AW'(i) || cnn_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL vga_line_issue %0d: got en=%0b addr=%0h gnt=%0b expected en=1 addr=%0h gnt=0",
                 i, fb_en, fb_addr, cnn_gnt, i);
      end
    end
    drive(1'b0, '0, 1'b1, 19'h0ABCD);
    expect_read(1'b1, 19'h0ABCD);
    n_checks++;
    if (cnn_gnt !== 1'b1 || fb_en !== 1'b1 || fb_addr !== 19'h0ABCD) begin
      n_fail++;
      $display("FAIL blank_first_grant: got gnt=%0b en=%0b addr=%0h expected 1 1 0abcd",
               cnn_gnt, fb_en, fb_addr);
    end
    drive(1'b0, '0, 1'b0, '0);
    n_checks++;
    if (fb_en !== 1'b0 || cnn_gnt !== 1'b0 || fb_addr !== 19'h0ABCD) begin
      n_fail++;
      $display("FAIL idle_addr_hold: got en=%0b gnt=%0b addr=%0h expected 0 0 0abcd",
               fb_en, cnn_gnt, fb_addr);
    end
    drive(1'b0, '0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, '0);
`ifdef ARB_STATS_EN
    exp_wm = 16'd640;
`else
    exp_wm = 16'd0;
`endif
    n_checks++;
    if (stat_wait_max !== exp_wm) begin
      n_fail++;
      $display("FAIL stat_wait_max_line: got %0d expected %0d", stat_wait_max, exp_wm);
    end
  endtask

  task automatic test_cnn_burst;
    logic [AW-1:0] a;
    logic          g;
    a = 19'h12340;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b1, a);
      g = (i != 8) && (i != 17);
      n_checks++;
      if (cnn_gnt !== g || fb_en !== g) begin
        n_fail++;
        $display("FAIL burst_grant %0d: got gnt=%0b en=%0b expected %0b", i, cnn_gnt, fb_en, g);
      end
      if (g) begin
        n_checks++;
        if (fb_addr !== a) begin
          n_fail++;
          $display("FAIL burst_addr %0d: got %0h expected %0h", i, fb_addr, a);
        end
        expect_read(1'b1, a);
        a = a + 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_preempt;
    logic [AW-1:0] a;
    logic [15:0]   exp_pre;
    a = 19'h2A005;
    for (int i = 0; i < 6; i++) begin
      if (i == 2 || i == 3) begin
        drive(1'b1, AW'(32'h100 + i), 1'b1, a);
        expect_read(1'b0, AW'(32'h100 + i));
        n_checks++;
        if (cnn_gnt !== 1'b0 || fb_en !== 1'b1 || fb_addr !== AW'(32'h100 + i)) begin
          n_fail++;
          $display("FAIL preempt_vga %0d: got gnt=%0b en=%0b addr=%0h expected 0 1 %0h",
                   i, cnn_gnt, fb_en, fb_addr, 32'h100 + i);
        end
      end else begin
        drive(1'b0, '0, 1'b1, a);
        n_checks++;
        if (cnn_gnt !== 1'b1 || fb_addr !== a) begin
          n_fail++;
          $display("FAIL preempt_cnn %0d: got gnt=%0b addr=%0h expected 1 %0h", i, cnn_gnt, fb_addr, a);
        end
        expect_read(1'b1, a);
        a = a + 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, '0);
`ifdef ARB_STATS_EN
    exp_pre = 16'd1;
`else
    exp_pre = 16'd0;
`endif
    n_checks++;
    if (stat_preempt !== exp_pre) begin
      n_fail++;
      $display("FAIL stat_preempt: got %0d expected %0d", stat_preempt, exp_pre);
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(32'h300 + i), (i == 1), 19'h00777);
      expect_read(1'b0, AW'(32'h300 + i));
      n_checks++;
      if (cnn_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_gnt %0d: got %0b expected 0", i, cnn_gnt);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0, '0);
      n_checks++;
      if (cnn_gnt !== 1'b0 || fb_en !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle %0d: got gnt=%0b en=%0b expected 0 0", i, cnn_gnt, fb_en);
      end
    end
  endtask

  task automatic test_reset_inflight;
    drive(1'b1, 19'h00005, 1'b0, '0);
    expect_read(1'b0, 19'h00005);
    drive(1'b0, '0, 1'b1, 19'h00009);
    expect_read(1'b1, 19'h00009);
    n_checks++;
    if (cnn_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_grant: got %0b expected 1", cnn_gnt);
    end
    @(posedge clk24);
    #1;
    vga_req = 1'b0;
    cnn_req = 1'b0;
    rst     = 1'b1;
    sb.delete();
    #2;
    n_checks++;
    if ({fb_en, cnn_gnt, vga_pvalid, cnn_rvalid, fb_addr, vga_pixel, cnn_rdata,
         stat_wait_max, stat_preempt} !== '0) begin
      n_fail++;
      $display("FAIL inflight_reset_outputs: got en=%0b gnt=%0b pv=%0b rv=%0b addr=%0h pix=%0h rd=%0h wm=%0d pre=%0d expected all 0",
               fb_en, cnn_gnt, vga_pvalid, cnn_rvalid, fb_addr, vga_pixel, cnn_rdata,
               stat_wait_max, stat_preempt);
    end
    drive(1'b0, '0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, '0);
    @(posedge clk24);
    #1 rst = 1'b0;
    drive(1'b0, '0, 1'b1, 19'h0000C);
    expect_read(1'b1, 19'h0000C);
    n_checks++;
    if (cnn_gnt !== 1'b1 || fb_addr !== 19'h0000C) begin
      n_fail++;
      $display("FAIL post_reset_idle_grant: got gnt=%0b addr=%0h expected 1 0000c", cnn_gnt, fb_addr);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    test_reset;
    test_vga_line;
    test_cnn_burst;
    test_preempt;
    test_abort;
    test_reset_inflight;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
